// File: rtl/gyro_pkg.sv
// Shared state type, default tuning constants and saturating arithmetic
// for the gyro angle tracking path.
package gyro_pkg;

  typedef enum logic {CAL, RUN} state_e;

  localparam int RATE_W        = 16;
  localparam int CAL_SHIFT_DEF = 4;
  localparam int DEADBAND_DEF  = 64;
  localparam int ANGLE_W_DEF   = 32;
  localparam logic signed [31:0] TILT_THRESH_DEF = 32'sd200000;

  // Sum of a and b clamped to the signed range of a w-bit word (w <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    logic signed [63:0] sum;
    maxV = (64'sd1 <<< (w - 1)) - 64'sd1;
    minV = -(64'sd1 <<< (w - 1));
    sum  = a + b;
    if (sum > maxV) return maxV;
    if (sum < minV) return minV;
    return sum;
  endfunction

endpackage

// File: rtl/gyro_axis_integrator.sv
// One gyro axis: zero-rate bias calibration, bias removal with deadband,
// saturating angle accumulator and tilt threshold flags.
module gyro_axis_integrator
  import gyro_pkg::*;
#(
  parameter int                CAL_SHIFT   = CAL_SHIFT_DEF,
  parameter int                DEADBAND    = DEADBAND_DEF,
  parameter int                ANGLE_W     = ANGLE_W_DEF,
  parameter logic signed [31:0] TILT_THRESH = TILT_THRESH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [RATE_W-1:0]  rate_i,
  input  logic                      cal_acc_i,
  input  logic                      cal_latch_i,
  input  logic                      run_sample_i,
  input  logic                      clr_i,
  output logic signed [ANGLE_W-1:0] angle_o,
  output logic                      angle_valid_o,
  output logic [1:0]                tilt_o
);

  localparam int SUM_W = RATE_W + CAL_SHIFT;
  localparam logic signed [63:0] THR_POS = {{32{TILT_THRESH[31]}}, TILT_THRESH};
  localparam logic signed [63:0] THR_NEG = -THR_POS;

  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic signed [RATE_W-1:0]  bias_q, bias_d;
  logic signed [RATE_W:0]    diff;
  logic signed [RATE_W:0]    corr_q, corr_d;
  logic                      s1Valid_q;
  logic signed [ANGLE_W-1:0] angle_q, angle_d;
  logic                      angleValid_q;
  logic [1:0]                tilt_q, tilt_d;
  logic signed [63:0]        accWide, corrWide, satWide;

  // The latch cycle uses the sum including the final calibration sample.
  always_comb begin
    sum_d    = sum_q + $signed({{CAL_SHIFT{rate_i[RATE_W-1]}}, rate_i});
    bias_d   = RATE_W'(sum_d >>> CAL_SHIFT);
    diff     = $signed({rate_i[RATE_W-1], rate_i}) - $signed({bias_q[RATE_W-1], bias_q});
    corr_d   = ((int'(diff) > DEADBAND) || (int'(diff) < -DEADBAND)) ? diff : '0;
    accWide  = {{(64-ANGLE_W){angle_q[ANGLE_W-1]}}, angle_q};
    corrWide = {{(63-RATE_W){corr_q[RATE_W]}}, corr_q};
    satWide  = sat_add(accWide, corrWide, ANGLE_W);
    angle_d  = ANGLE_W'(satWide);
    tilt_d   = {satWide < THR_NEG, satWide > THR_POS};
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sum_q        <= '0;
      bias_q       <= '0;
      corr_q       <= '0;
      s1Valid_q    <= 1'b0;
      angle_q      <= '0;
      angleValid_q <= 1'b0;
      tilt_q       <= '0;
    end else begin
      if (cal_acc_i)    sum_q  <= sum_d;
      if (cal_latch_i)  bias_q <= bias_d;
      if (run_sample_i) corr_q <= corr_d;
      s1Valid_q    <= run_sample_i;
      angleValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        angle_q <= angle_d;
        tilt_q  <= tilt_d;
      end
    end
  end

  assign angle_o       = angle_q;
  assign angle_valid_o = angleValid_q;
  assign tilt_o        = tilt_q;

endmodule

// File: rtl/gyro_motion_tracker.sv
// Gyro motion tracker: detects new rate triples, sequences calibration and
// run phases, and drives three per-axis angle integrators.
module gyro_motion_tracker
  import gyro_pkg::*;
#(
  parameter int                CAL_SHIFT   = CAL_SHIFT_DEF,
  parameter int                DEADBAND    = DEADBAND_DEF,
  parameter int                ANGLE_W     = ANGLE_W_DEF,
  parameter logic signed [31:0] TILT_THRESH = TILT_THRESH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [RATE_W-1:0]  x_rate_i,
  input  logic signed [RATE_W-1:0]  y_rate_i,
  input  logic signed [RATE_W-1:0]  z_rate_i,
  input  logic                      recal_i,
  output logic                      cal_done_o,
  output logic signed [ANGLE_W-1:0] angle_x_o,
  output logic signed [ANGLE_W-1:0] angle_y_o,
  output logic signed [ANGLE_W-1:0] angle_z_o,
  output logic                      angle_valid_o,
  output logic [5:0]                tilt_o
);

  logic signed [RATE_W-1:0] prevX_q, prevY_q, prevZ_q;
  state_e                   state_q;
  logic [CAL_SHIFT:0]       sampleCnt_q;
  logic                     calDone_q;
  logic                     newSample, sampleTake;
  logic                     calAcc, calLatch, runSample;
  logic [2:0]               axisValid;
  logic [1:0]               tiltX, tiltY, tiltZ;

  // The rate words carry no strobe, so any change of the triple is a sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      prevX_q <= '0;
      prevY_q <= '0;
      prevZ_q <= '0;
    end else begin
      prevX_q <= x_rate_i;
      prevY_q <= y_rate_i;
      prevZ_q <= z_rate_i;
    end
  end

  assign newSample  = (x_rate_i != prevX_q) || (y_rate_i != prevY_q) || (z_rate_i != prevZ_q);
  assign sampleTake = newSample && !recal_i;
  assign calAcc     = (state_q == CAL) && sampleTake;
  assign calLatch   = calAcc && (int'(sampleCnt_q) == (1 << CAL_SHIFT) - 1);
  assign runSample  = (state_q == RUN) && sampleTake;

  always_ff @(posedge clk) begin
    if (rst || recal_i) begin
      state_q     <= CAL;
      sampleCnt_q <= '0;
      calDone_q   <= 1'b0;
    end else if (state_q == CAL) begin
      if (calAcc) sampleCnt_q <= sampleCnt_q + 1'b1;
      if (calLatch) begin
        state_q   <= RUN;
        calDone_q <= 1'b1;
      end
    end
  end

  gyro_axis_integrator #(
    .CAL_SHIFT(CAL_SHIFT), .DEADBAND(DEADBAND), .ANGLE_W(ANGLE_W), .TILT_THRESH(TILT_THRESH)
  ) uAxisX (
    .clk(clk), .rst(rst), .rate_i(x_rate_i), .cal_acc_i(calAcc), .cal_latch_i(calLatch),
    .run_sample_i(runSample), .clr_i(recal_i), .angle_o(angle_x_o),
    .angle_valid_o(axisValid[0]), .tilt_o(tiltX)
  );

  gyro_axis_integrator #(
    .CAL_SHIFT(CAL_SHIFT), .DEADBAND(DEADBAND), .ANGLE_W(ANGLE_W), .TILT_THRESH(TILT_THRESH)
  ) uAxisY (
    .clk(clk), .rst(rst), .rate_i(y_rate_i), .cal_acc_i(calAcc), .cal_latch_i(calLatch),
    .run_sample_i(runSample), .clr_i(recal_i), .angle_o(angle_y_o),
    .angle_valid_o(axisValid[1]), .tilt_o(tiltY)
  );

  gyro_axis_integrator #(
    .CAL_SHIFT(CAL_SHIFT), .DEADBAND(DEADBAND), .ANGLE_W(ANGLE_W), .TILT_THRESH(TILT_THRESH)
  ) uAxisZ (
    .clk(clk), .rst(rst), .rate_i(z_rate_i), .cal_acc_i(calAcc), .cal_latch_i(calLatch),
    .run_sample_i(runSample), .clr_i(recal_i), .angle_o(angle_z_o),
    .angle_valid_o(axisValid[2]), .tilt_o(tiltZ)
  );

  assign cal_done_o    = calDone_q;
  assign angle_valid_o = &axisValid;
  assign tilt_o        = {tiltZ, tiltY, tiltX};

endmodule

// File: tb/tb_gyro_motion_tracker.sv
// Self-checking bench for gyro_motion_tracker: a default-width instance and a
// narrow 16-bit instance for saturation, both compared to a behavioural model.
module tb_gyro_motion_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic signed [15:0] rate [2][3];
  logic              recal [2];

  logic              calDone0, valid0;
  logic [5:0]        tilt0;
  logic signed [31:0] ax0, ay0, az0;
  logic              calDone1, valid1;
  logic [5:0]        tilt1;
  logic signed [15:0] ax1, ay1, az1;

  int checks   = 0;
  int failures = 0;

  gyro_motion_tracker dut0 (
    .clk(clk), .rst(rst), .x_rate_i(rate[0][0]), .y_rate_i(rate[0][1]), .z_rate_i(rate[0][2]),
    .recal_i(recal[0]), .cal_done_o(calDone0), .angle_x_o(ax0), .angle_y_o(ay0),
    .angle_z_o(az0), .angle_valid_o(valid0), .tilt_o(tilt0)
  );

  gyro_motion_tracker #(.ANGLE_W(16), .TILT_THRESH(32'sd1000)) dut1 (
    .clk(clk), .rst(rst), .x_rate_i(rate[1][0]), .y_rate_i(rate[1][1]), .z_rate_i(rate[1][2]),
    .recal_i(recal[1]), .cal_done_o(calDone1), .angle_x_o(ax1), .angle_y_o(ay1),
    .angle_z_o(az1), .angle_valid_o(valid1), .tilt_o(tilt1)
  );

  wire [103:0] obs0 = {calDone0, valid0, tilt0, ax0, ay0, az0};
  wire [55:0]  obs1 = {calDone1, valid1, tilt1, ax1, ay1, az1};

  // Behavioural model: calibration averages 16 samples, run samples land two clocks later.
  bit     mCal [2];
  int     mCount [2];
  longint mSum [2][3], mBias [2][3], mPend [2][3], mAngle [2][3], mPrev [2][3];
  bit     mPendValid [2], mValid [2];
  bit [5:0] mTilt [2];
  logic [103:0] exp0;
  logic [55:0]  exp1;

  task automatic model_step(input int u);
    longint lim, thr, c, q;
    bit chg;
    lim = (u == 0) ? 64'sd2147483647 : 64'sd32767;
    thr = (u == 0) ? 64'sd200000 : 64'sd1000;
    chg = 1'b0;
    for (int a = 0; a < 3; a++) if (longint'(rate[u][a]) != mPrev[u][a]) chg = 1'b1;
    if (rst || recal[u]) begin
      mCal[u] = 0; mCount[u] = 0; mPendValid[u] = 0; mValid[u] = 0; mTilt[u] = '0;
      for (int a = 0; a < 3; a++) begin
        mSum[u][a] = 0; mBias[u][a] = 0; mPend[u][a] = 0; mAngle[u][a] = 0;
      end
    end else begin
      mValid[u] = mPendValid[u];
      if (mPendValid[u]) begin
        for (int a = 0; a < 3; a++) begin
          c = mAngle[u][a] + mPend[u][a];
          if (c > lim) c = lim;
          if (c < -lim - 1) c = -lim - 1;
          mAngle[u][a] = c;
          mTilt[u][2*a]   = (c > thr);
          mTilt[u][2*a+1] = (c < -thr);
        end
      end
      mPendValid[u] = 0;
      if (chg) begin
        if (!mCal[u]) begin
          mCount[u]++;
          for (int a = 0; a < 3; a++) mSum[u][a] += longint'(rate[u][a]);
          if (mCount[u] == 16) begin
            for (int a = 0; a < 3; a++) begin
              q = mSum[u][a] / 16;
              if ((mSum[u][a] % 16) != 0 && mSum[u][a] < 0) q = q - 1;
              mBias[u][a] = q;
            end
            mCal[u] = 1;
          end
        end else begin
          for (int a = 0; a < 3; a++) begin
            c = longint'(rate[u][a]) - mBias[u][a];
            if (c >= -64 && c <= 64) c = 0;
            mPend[u][a] = c;
          end
          mPendValid[u] = 1;
        end
      end
    end
    for (int a = 0; a < 3; a++) mPrev[u][a] = rst ? 0 : longint'(rate[u][a]);
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    exp0 = {mCal[0], mValid[0], mTilt[0], 32'(mAngle[0][0]), 32'(mAngle[0][1]), 32'(mAngle[0][2])};
    exp1 = {mCal[1], mValid[1], mTilt[1], 16'(mAngle[1][0]), 16'(mAngle[1][1]), 16'(mAngle[1][2])};
  end

  // Applies one input triple (and optional recal pulse) across one rising edge.
  task automatic drive(input int u, input int x, input int y, input int z, input bit rc);
    rate[u][0] = 16'(x);
    rate[u][1] = 16'(y);
    rate[u][2] = 16'(z);
    recal[u]   = rc;
    @(negedge clk);
    recal[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      recal[u] = 1'b0;
      for (int a = 0; a < 3; a++) rate[u][a] = '0;
    end
    repeat (3) begin
      @(negedge clk);
      checks += 2;
      if (obs0 !== '0) begin failures++; $display("[TB] FAIL reset0: got %h expected 0", obs0); end
      if (obs1 !== '0) begin failures++; $display("[TB] FAIL reset1: got %h expected 0", obs1); end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 5, 5, 5, 0);
      checks++;
      if (obs0 !== exp0) begin failures++; $display("[TB] FAIL hold_const: got %h expected %h", obs0, exp0); end
    end
    for (int i = 0; i < 15; i++) begin
      drive(0, 1000 + i, 5, 5, 0);
      checks += 2;
      if (obs0 !== exp0) begin failures++; $display("[TB] FAIL one_sample_model: got %h expected %h", obs0, exp0); end
      if (calDone0 !== 1'(i == 14)) begin failures++; $display("[TB] FAIL one_sample_caldone i=%0d: got %b expected %b", i, calDone0, (i == 14)); end
    end
  endtask

  task automatic test_calibration();
    drive(0, 1014, 5, 5, 1);
    checks++;
    if ({calDone0, obs0} !== {1'b0, exp0}) begin failures++; $display("[TB] FAIL recal_cal: got %h expected %h", obs0, exp0); end
    for (int i = 0; i < 16; i++) begin
      drive(0, (i % 2) ? 102 : 98, (i % 2) ? 2 : 0, (i % 2) ? -6 : -10, 0);
      checks += 2;
      if (obs0 !== exp0) begin failures++; $display("[TB] FAIL cal_model: got %h expected %h", obs0, exp0); end
      if ({calDone0, valid0} !== {1'(i == 15), 1'b0}) begin
        failures++; $display("[TB] FAIL cal_done i=%0d: got %b%b expected %b0", i, calDone0, valid0, (i == 15));
      end
    end
  endtask

  task automatic test_integration();
    drive(0, 300, 2, -6, 0);
    checks++;
    if ({valid0, ax0} !== {1'b0, 32'sd0}) begin failures++; $display("[TB] FAIL latency: got %b/%0d expected 0/0", valid0, ax0); end
    drive(0, 301, 2, -6, 0);
    checks++;
    if ({valid0, ax0, ay0, az0} !== {1'b1, 32'sd200, 32'sd0, 32'sd0}) begin
      failures++; $display("[TB] FAIL integ200: got %b/%0d/%0d/%0d expected 1/200/0/0", valid0, ax0, ay0, az0);
    end
    drive(0, 150, 2, -6, 0);
    checks++;
    if ({valid0, ax0} !== {1'b1, 32'sd401}) begin failures++; $display("[TB] FAIL integ401: got %b/%0d expected 1/401", valid0, ax0); end
    drive(0, 150, 2, -6, 0);
    checks += 2;
    if ({valid0, ax0} !== {1'b1, 32'sd401}) begin failures++; $display("[TB] FAIL deadband: got %b/%0d expected 1/401", valid0, ax0); end
    if (obs0 !== exp0) begin failures++; $display("[TB] FAIL integ_model: got %h expected %h", obs0, exp0); end
  endtask

  task automatic test_repeat();
    for (int i = 0; i < 100; i++) begin
      drive(0, 150, 2, -6, 0);
      checks++;
      if ({valid0, ax0, obs0} !== {1'b0, 32'sd401, exp0}) begin
        failures++; $display("[TB] FAIL repeat i=%0d: got %b/%0d expected 0/401", i, valid0, ax0);
      end
    end
  endtask

  task automatic test_recal();
    drive(0, 400, 2, -6, 1);
    checks++;
    if ({calDone0, valid0, tilt0, ax0, ay0, az0} !== '0) begin
      failures++; $display("[TB] FAIL recal_collision: got %h expected 0", obs0);
    end
    drive(0, 400, 2, -6, 0);
    checks++;
    if ({valid0, obs0} !== {1'b0, exp0}) begin failures++; $display("[TB] FAIL recal_drop: got %h expected %h", obs0, exp0); end
    for (int i = 0; i < 16; i++) begin
      drive(0, 500 + i, 3, 3, 0);
      checks++;
      if ({calDone0, obs0} !== {1'(i == 15), exp0}) begin
        failures++; $display("[TB] FAIL recal_count i=%0d: got %b expected %b", i, calDone0, (i == 15));
      end
    end
    drive(0, 2000, 3, 3, 0);
    drive(0, 2000, 3, 3, 1);
    checks++;
    if ({calDone0, valid0, tilt0, ax0} !== '0) begin failures++; $display("[TB] FAIL recal_inflight: got %h expected 0", obs0); end
    drive(0, 2000, 3, 3, 0);
    checks++;
    if ({valid0, ax0, obs0} !== {1'b0, 32'sd0, exp0}) begin failures++; $display("[TB] FAIL recal_inflight_drop: got %h expected %h", obs0, exp0); end
  endtask

  task automatic test_random();
    int cx, cy, cz;
    bit rc;
    cx = 2000; cy = 3; cz = 3;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) >= 3) begin
        cx = int'($urandom_range(0, 65535)) - 32768;
        cy = int'($urandom_range(0, 255)) - 128;
        cz = int'($urandom_range(0, 65535)) - 32768;
      end
      rc = ($urandom_range(0, 59) == 0);
      drive(0, cx, cy, cz, rc);
      checks++;
      if (obs0 !== exp0) begin failures++; $display("[TB] FAIL random i=%0d: got %h expected %h", i, obs0, exp0); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) begin
      drive(1, (i % 2) ? -1 : 1, 0, 0, 0);
      checks++;
      if ({calDone1, obs1} !== {1'(i == 15), exp1}) begin failures++; $display("[TB] FAIL sat_cal i=%0d: got %h expected %h", i, obs1, exp1); end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, (i % 2) ? 32001 : 32000, 0, 0, 0);
      checks++;
      if (obs1 !== exp1) begin failures++; $display("[TB] FAIL sat_pos_model i=%0d: got %h expected %h", i, obs1, exp1); end
    end
    drive(1, 32001, 0, 0, 0);
    checks++;
    if ({ax1, tilt1[1:0]} !== {16'sd32767, 2'b01}) begin failures++; $display("[TB] FAIL sat_pos: got %0d/%b expected 32767/01", ax1, tilt1[1:0]); end
    for (int i = 0; i < 6; i++) begin
      drive(1, (i % 2) ? -32001 : -32000, 0, 0, 0);
      checks++;
      if (obs1 !== exp1) begin failures++; $display("[TB] FAIL sat_neg_model i=%0d: got %h expected %h", i, obs1, exp1); end
    end
    drive(1, -32001, 0, 0, 0);
    checks++;
    if ({ax1, tilt1[1:0]} !== {-16'sd32768, 2'b10}) begin failures++; $display("[TB] FAIL sat_neg: got %0d/%b expected -32768/10", ax1, tilt1[1:0]); end
  endtask

  initial begin
    test_reset();
    test_calibration();
    test_integration();
    test_repeat();
    test_recal();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
